// File: rtl/nib_track_sync.sv
// Moves one Disk II track between the mounted NIB image and the track buffer RAM, 13 SD sectors at a time.
// Define NIB_WRITEBACK_EN to write a dirty track back to the image before the next track is loaded.
module nib_track_sync #(
  parameter int SECTORS = 13,
  parameter int TRK_W   = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [TRK_W-1:0] track,
  input  logic             img_mounted,
  input  logic             img_valid,
  input  logic             track_wr,
  input  logic             sd_ack,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [3:0]       track_sec,
  output logic             cpu_wait,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd2;
`ifdef NIB_WRITEBACK_EN
  localparam logic [1:0] FLUSH = 2'd1;
`endif
  localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

  logic [1:0]       state;
  logic [TRK_W-1:0] cur_track;
  logic             mount_pend;
  logic             old_ack;
  logic             ack_rise;
  logic             ack_fall;
  logic             mount_ev;
  logic             trigger;
  logic             req;
`ifdef NIB_WRITEBACK_EN
  logic             dirty;
`else
  logic             unused_track_wr;

  assign unused_track_wr = track_wr;
  assign sd_wr           = 1'b0;
`endif

  function automatic logic [31:0] track_lba(input logic [TRK_W-1:0] t);
    return 32'(SECTORS) * 32'(t);
  endfunction

  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;
  assign mount_ev = img_mounted | mount_pend;
  assign trigger  = (track != cur_track) | mount_ev;
  assign req      = sd_rd | sd_wr;
  assign busy     = (state != IDLE);

  // A falling ack edge while the request is already low closes the current phase.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_track  <= '0;
      mount_pend <= 1'b0;
      old_ack    <= 1'b0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      track_sec  <= '0;
      cpu_wait   <= 1'b0;
`ifdef NIB_WRITEBACK_EN
      sd_wr      <= 1'b0;
      dirty      <= 1'b0;
`endif
    end else begin
      old_ack <= sd_ack;
      if (state != IDLE && img_mounted)
        mount_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            mount_pend <= 1'b0;
            if (!img_valid) begin
              cur_track <= track;
`ifdef NIB_WRITEBACK_EN
              dirty     <= 1'b0;
            end else if (dirty && !mount_ev) begin
              // Old track goes out first; cur_track still names it until the flush ends.
              state     <= FLUSH;
              sd_lba    <= track_lba(cur_track);
              sd_wr     <= 1'b1;
              track_sec <= '0;
              cpu_wait  <= 1'b1;
`endif
            end else begin
              state     <= LOAD;
              sd_lba    <= track_lba(track);
              sd_rd     <= 1'b1;
              cur_track <= track;
              track_sec <= '0;
              cpu_wait  <= 1'b1;
`ifdef NIB_WRITEBACK_EN
              dirty     <= 1'b0;
`endif
            end
          end
`ifdef NIB_WRITEBACK_EN
          else if (track_wr) begin
            dirty <= 1'b1;
          end
`endif
        end

        default: begin
          if (ack_rise) begin
            sd_lba <= sd_lba + 32'd1;
            if (track_sec == LAST_SEC) begin
              sd_rd <= 1'b0;
`ifdef NIB_WRITEBACK_EN
              sd_wr <= 1'b0;
`endif
            end
          end

          if (ack_fall) begin
            if (track_sec != LAST_SEC)
              track_sec <= track_sec + 4'd1;
            if (!req) begin
`ifdef NIB_WRITEBACK_EN
              if (state == FLUSH) begin
                dirty     <= 1'b0;
                state     <= LOAD;
                cur_track <= track;
                sd_lba    <= track_lba(track);
                sd_rd     <= 1'b1;
                track_sec <= '0;
              end else begin
                state    <= IDLE;
                cpu_wait <= 1'b0;
              end
`else
              state    <= IDLE;
              cpu_wait <= 1'b0;
`endif
            end
          end
        end
      endcase
    end
  end

  assert property (@(posedge clk_sys) disable iff (reset) !(sd_rd && sd_wr));

endmodule
